// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//
// Serial bit-stream generator. A parallel pattern is captured when START is
// accepted in IDLE and shifted out MSB first, one bit per clock, on X. It is
// meant to feed the X input of the lab's Moore sequence-detector FSMs.
//
// Parameters:
//   WIDTH   pattern register width in bits (2..32)
//   CNT_W   width of LENGTH and the bit counter (2**CNT_W > WIDTH)
//
// Ports:
//   CLOCK         in   rising-edge clock
//   RESET         in   asynchronous, active-high reset
//   START         in   transmit request, only looked at in IDLE
//   PATTERN       in   [WIDTH-1:0] bits to send, MSB first
//   LENGTH        in   [CNT_W-1:0] number of bits to send (clamped to WIDTH)
//   PAUSE         in   freezes transmission while high
//   REPEAT        in   (SERIAL_TX_LOOP_EN only) resend the captured pattern
//   X             out  registered serial data, idles at 1
//   BUSY          out  high in SHIFT or HOLD
//   DONE          out  one-cycle pulse in the DONE state
//   CurrentState  out  [1:0] IDLE=0, SHIFT=1, HOLD=2, DONE=3
//
// Optional feature macro: SERIAL_TX_LOOP_EN
//   When defined, a REPEAT input and a copy of the accepted pattern/length
//   are added so the stream can be replayed with one idle-level gap cycle
//   (the DONE cycle) between repetitions.
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] PATTERN,
    input  logic [CNT_W-1:0] LENGTH,
    input  logic             PAUSE,
`ifdef SERIAL_TX_LOOP_EN
    input  logic             REPEAT,
`endif
    output logic             X,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       CurrentState
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic             x_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] len_eff;

`ifdef SERIAL_TX_LOOP_EN
    logic [WIDTH-1:0] copy_pat;
    logic [WIDTH-1:0] copy_pat_next;
    logic [CNT_W-1:0] copy_len;
    logic [CNT_W-1:0] copy_len_next;
`endif

    // A LENGTH longer than the pattern register just sends the whole pattern.
    assign len_eff = (LENGTH > WIDTH_CNT) ? WIDTH_CNT : LENGTH;

    // Moore status outputs depend on the state register only.
    assign BUSY         = (state == ST_SHIFT) || (state == ST_HOLD);
    assign DONE         = (state == ST_DONE);
    assign CurrentState = state;

    // State and datapath registers. The counter holds the number of bits still
    // to be sent after the one currently on X, so zero means "last bit".
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            X        <= 1'b1;
            shreg    <= '0;
            cnt      <= '0;
`ifdef SERIAL_TX_LOOP_EN
            copy_pat <= '0;
            copy_len <= '0;
`endif
        end else begin
            state    <= state_next;
            X        <= x_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
`ifdef SERIAL_TX_LOOP_EN
            copy_pat <= copy_pat_next;
            copy_len <= copy_len_next;
`endif
        end
    end

    // Next-state and datapath logic. Everything defaults to "hold", so HOLD
    // only needs to decide when to leave; re-entering SHIFT from HOLD does not
    // shift, which stretches the paused bit by one extra cycle.
    always_comb begin
        state_next    = state;
        x_next        = X;
        shreg_next    = shreg;
        cnt_next      = cnt;
`ifdef SERIAL_TX_LOOP_EN
        copy_pat_next = copy_pat;
        copy_len_next = copy_len;
`endif
        case (state)
            ST_IDLE: begin
                x_next = 1'b1;
                if (START) begin
`ifdef SERIAL_TX_LOOP_EN
                    copy_pat_next = PATTERN;
                    copy_len_next = len_eff;
`endif
                    if (len_eff == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        x_next     = PATTERN[WIDTH-1];
                        shreg_next = PATTERN << 1;
                        cnt_next   = len_eff - CNT_ONE;
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (PAUSE) begin
                    state_next = ST_HOLD;
                end else if (cnt != '0) begin
                    x_next     = shreg[WIDTH-1];
                    shreg_next = shreg << 1;
                    cnt_next   = cnt - CNT_ONE;
                end else begin
                    x_next     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (!PAUSE) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                x_next     = 1'b1;
                state_next = ST_IDLE;
`ifdef SERIAL_TX_LOOP_EN
                // Replay straight from DONE so the gap between copies is
                // exactly this one idle-level cycle.
                if (REPEAT && (copy_len != '0)) begin
                    x_next     = copy_pat[WIDTH-1];
                    shreg_next = copy_pat << 1;
                    cnt_next   = copy_len - CNT_ONE;
                    state_next = ST_SHIFT;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
                x_next     = 1'b1;
            end
        endcase
    end

endmodule
